// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the HUB75-style panel receiver.
//   RGB_W    : number of colour channels carried on the serial rgb bus
//   rd_chan_e: readout channel select encoding used on rd_chan
//              (CH_R/CH_G/CH_B pick a colour accumulator, CH_FRAME picks the
//              frame cycle count and ignores the row select)
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int RGB_W = 3;

    typedef enum logic [1:0] {
        CH_R     = 2'd0,
        CH_G     = 2'd1,
        CH_B     = 2'd2,
        CH_FRAME = 2'd3
    } rd_chan_e;

endpackage

// File: rtl/display_panel_receiver_if.sv
// -----------------------------------------------------------------------------
// display_panel_receiver_if
// Panel-side serial bus plus the statistics readout port.
//   master : the panel driver / bench side (drives rgb, oclk, lat, oe, addr,
//            rd_row, rd_chan; observes rd_data, frame_tick, err)
//   slave  : the receiver side
// Signal summary:
//   rgb[2:0]   serial pixel bits {b,g,r}
//   oclk       shift clock, acted on at its rising edge (sampled in clk)
//   lat        latch strobe, acted on at its rising edge; addr sampled then
//   oe         1 = latched row is lit this cycle
//   addr       row address
//   rd_row     readout row select
//   rd_chan    readout channel select (rd_chan_e encoding)
//   rd_data    registered readout value, one cycle after rd_row/rd_chan
//   frame_tick one-cycle pulse: a new snapshot is available
//   err        sticky protocol error flags
// Handshake: there is no valid/ready pair and no backpressure. oclk and lat
// are edge strobes that are always accepted on the cycle their level first
// reads high; rd_data is a free-running registered lookup and frame_tick is
// the only qualifier, marking the first cycle a fresh snapshot is visible.
// -----------------------------------------------------------------------------
interface display_panel_receiver_if
    import display_pkg::*;
#(
    parameter int rows     = 8,
    parameter int cntwidth = 24
);
    localparam int aw = $clog2(rows);

    logic [RGB_W-1:0]    rgb;
    logic                oclk;
    logic                lat;
    logic                oe;
    logic [aw-1:0]       addr;
    logic [aw-1:0]       rd_row;
    logic [1:0]          rd_chan;
    logic [cntwidth-1:0] rd_data;
    logic                frame_tick;
    logic [1:0]          err;

    modport master (
        output rgb, oclk, lat, oe, addr, rd_row, rd_chan,
        input  rd_data, frame_tick, err
    );

    modport slave (
        input  rgb, oclk, lat, oe, addr, rd_row, rd_chan,
        output rd_data, frame_tick, err
    );

endinterface

// File: rtl/display_edge_detect.sv
// -----------------------------------------------------------------------------
// display_edge_detect
// Rising-edge detector with one bit of registered history.
//   clk  : system clock
//   rst  : asynchronous active-low reset (history clears to 0)
//   din  : level input, synchronous to clk
//   rise : din & ~din_q, combinational so the edge is seen in the cycle
//          din first reads high
// -----------------------------------------------------------------------------
module display_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/display_panel_receiver.sv
// -----------------------------------------------------------------------------
// display_panel_receiver
// Sink end of a HUB75-style pulse-width panel interface. Shifts column data
// in on oclk rising edges, latches a row on lat rising edges, and counts the
// lit cycles of one probe column per row and colour. At every row-address
// wrap the counters and the frame cycle count are snapshotted and published
// through a small registered readout port.
// Ports:
//   clk  : system clock (driver clock domain)
//   rst  : asynchronous active-low reset
//   pins : display_panel_receiver_if.slave (serial bus, readout, err)
// Parameters: rows, columns, cntwidth, probe_column.
// Build option: define PANEL_RX_ERRCHK_EN to generate the sticky protocol
// checks on err; otherwise err is tied to 0.
// -----------------------------------------------------------------------------
module display_panel_receiver
    import display_pkg::*;
#(
    parameter int rows         = 8,
    parameter int columns      = 32,
    parameter int cntwidth     = 24,
    parameter int probe_column = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    display_panel_receiver_if.slave  pins
);

    localparam int aw = $clog2(rows);
    // First bit shifted is column 0, so column c ends up at columns-1-c.
    localparam int tap = columns - 1 - probe_column;
    localparam logic [cntwidth-1:0] cnt_max = '1;

    logic                oclk_rise;
    logic                lat_rise;
    logic                boundary;
    logic [columns-1:0]  shreg [RGB_W];
    // Only the probe column of the latched row drives any output, so just
    // that column of each channel is kept at latch time.
    logic [RGB_W-1:0]    latch_probe;
    logic [aw-1:0]       latched_row;
    logic [cntwidth-1:0] acc  [rows][RGB_W];
    logic [cntwidth-1:0] snap [rows][RGB_W];
    logic                lit  [rows][RGB_W];
    logic [cntwidth-1:0] frame_cycles;
    logic [cntwidth-1:0] snap_frames;
    logic [cntwidth-1:0] rd_next;
    logic [cntwidth-1:0] rd_q;
    logic                tick_q;

    function automatic logic [cntwidth-1:0] sat_inc(input logic [cntwidth-1:0] v,
                                                    input logic en);
        return (en && (v != cnt_max)) ? v + cntwidth'(1) : v;
    endfunction

    display_edge_detect u_oclk_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (pins.oclk),
        .rise (oclk_rise)
    );

    display_edge_detect u_lat_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (pins.lat),
        .rise (lat_rise)
    );

    // A frame ends when the row address wraps back below the current row.
    assign boundary = lat_rise && (pins.addr < latched_row);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < RGB_W; ch++) begin
                shreg[ch] <= '0;
            end
            latch_probe <= '0;
            latched_row <= '0;
        end else begin
            if (oclk_rise) begin
                for (int ch = 0; ch < RGB_W; ch++) begin
                    shreg[ch] <= {shreg[ch][columns-2:0], pins.rgb[ch]};
                end
            end
            // Reads the pre-shift register, so a coincident oclk bit is
            // excluded from this latch and starts the next row instead.
            if (lat_rise) begin
                for (int ch = 0; ch < RGB_W; ch++) begin
                    latch_probe[ch] <= shreg[ch][tap];
                end
                latched_row <= pins.addr;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < rows; r++) begin
            for (int ch = 0; ch < RGB_W; ch++) begin
                lit[r][ch] = pins.oe && latch_probe[ch] && (latched_row == aw'(r));
            end
        end
    end

    // On a boundary the snapshot takes the pre-increment values and the
    // live counters restart with this cycle already counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < rows; r++) begin
                for (int ch = 0; ch < RGB_W; ch++) begin
                    acc[r][ch]  <= '0;
                    snap[r][ch] <= '0;
                end
            end
            frame_cycles <= '0;
            snap_frames  <= '0;
            tick_q       <= 1'b0;
        end else begin
            for (int r = 0; r < rows; r++) begin
                for (int ch = 0; ch < RGB_W; ch++) begin
                    if (boundary) begin
                        snap[r][ch] <= acc[r][ch];
                        acc[r][ch]  <= cntwidth'(lit[r][ch]);
                    end else begin
                        acc[r][ch]  <= sat_inc(acc[r][ch], lit[r][ch]);
                    end
                end
            end
            if (boundary) begin
                snap_frames  <= frame_cycles;
                frame_cycles <= cntwidth'(1);
            end else begin
                frame_cycles <= sat_inc(frame_cycles, 1'b1);
            end
            tick_q <= boundary;
        end
    end

    // On a boundary cycle the lookup bypasses to the values being
    // snapshotted, so rd_data already holds the new snapshot while
    // frame_tick is high.
    always_comb begin
        rd_next = '0;
        if (pins.rd_chan == CH_FRAME) begin
            rd_next = boundary ? frame_cycles : snap_frames;
        end else begin
            for (int ch = 0; ch < RGB_W; ch++) begin
                if (pins.rd_chan == 2'(ch)) begin
                    rd_next = boundary ? acc[pins.rd_row][ch] : snap[pins.rd_row][ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_next;
        end
    end

    assign pins.rd_data    = rd_q;
    assign pins.frame_tick = tick_q;

`ifdef PANEL_RX_ERRCHK_EN
    localparam int scw = $clog2(columns + 2);
    localparam logic [scw-1:0] shift_full = scw'(columns);
    localparam logic [scw-1:0] shift_sat  = scw'(columns + 1);

    logic [scw-1:0] shift_cnt;
    logic [1:0]     err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_cnt <= '0;
            err_q     <= '0;
        end else begin
            if (lat_rise) begin
                shift_cnt <= oclk_rise ? scw'(1) : '0;
            end else if (oclk_rise && (shift_cnt != shift_sat)) begin
                shift_cnt <= shift_cnt + scw'(1);
            end
            if (lat_rise && (shift_cnt != shift_full)) begin
                err_q[0] <= 1'b1;
            end
            if (pins.lat && pins.oe) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign pins.err = err_q;
`else
    assign pins.err = 2'b00;
`endif

endmodule

// File: tb/tb_display_panel_receiver.sv
module tb_display_panel_receiver;
    import display_pkg::*;

    localparam int ROWS  = 8;
    localparam int COLS  = 32;
    localparam int CW    = 24;
    localparam int PROBE = 0;
    localparam int AW    = $clog2(ROWS);
    localparam int EW    = CW + 3;
    localparam longint CMAX = (longint'(1) << CW) - 1;
`ifdef PANEL_RX_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    display_panel_receiver_if #(.rows(ROWS), .cntwidth(CW)) pins ();

    display_panel_receiver #(
        .rows(ROWS), .columns(COLS), .cntwidth(CW), .probe_column(PROBE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (pins)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Shifted history kept as a queue of pixel values; probe column is read
    // by its age in that history.
    logic [2:0] m_q[$];
    logic [2:0] m_probe;
    int         m_row;
    int         m_cnt;
    longint     m_acc  [ROWS][3];
    longint     m_snap [ROWS][3];
    longint     m_frames, m_snap_frames;
    bit         m_prev_oclk, m_prev_lat, m_tick;
    bit [1:0]   m_err;
    logic [EW-1:0] exp_q[$];

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [2:0] probe_bits();
        int age = COLS - 1 - PROBE;
        if (m_q.size() > age) return m_q[m_q.size() - 1 - age];
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_probe = '0; m_row = 0; m_cnt = 0;
        m_frames = 0; m_snap_frames = 0;
        m_prev_oclk = 0; m_prev_lat = 0; m_tick = 0; m_err = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 3; c++) begin
                m_acc[r][c] = 0; m_snap[r][c] = 0;
            end
    endtask

    task automatic model_step();
        bit oclk_r, lat_r, bnd;
        logic [2:0] pb;
        oclk_r = pins.oclk && !m_prev_oclk;
        lat_r  = pins.lat && !m_prev_lat;
        pb     = probe_bits();
        bnd    = lat_r && (int'(pins.addr) < m_row);
        if (bnd) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < 3; c++) begin
                    m_snap[r][c] = m_acc[r][c];
                    m_acc[r][c]  = 0;
                end
            m_snap_frames = m_frames;
            m_frames = 1;
        end else begin
            m_frames = sat(m_frames + 1);
        end
        if (pins.oe)
            for (int c = 0; c < 3; c++)
                m_acc[m_row][c] = sat(m_acc[m_row][c] + longint'(m_probe[c]));
        if (lat_r && m_cnt != COLS) m_err[0] = 1'b1;
        if (pins.lat && pins.oe)    m_err[1] = 1'b1;
        if (lat_r) begin
            m_probe = pb;
            m_row   = int'(pins.addr);
            m_cnt   = oclk_r ? 1 : 0;
        end else if (oclk_r) begin
            m_cnt = (m_cnt + 1 > COLS + 1) ? COLS + 1 : m_cnt + 1;
        end
        if (oclk_r) begin
            m_q.push_back(pins.rgb);
            if (m_q.size() > COLS) void'(m_q.pop_front());
        end
        m_prev_oclk = pins.oclk;
        m_prev_lat  = pins.lat;
        m_tick      = bnd;
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin : scoreboard
        logic [EW-1:0] e;
        logic [CW-1:0] rd_e;
        logic [1:0]    err_e;
        if (!rst) model_reset();
        else      model_step();
        rd_e = '0;
        if (rst) begin
            if (pins.rd_chan == CH_FRAME) rd_e = CW'(m_snap_frames);
            else rd_e = CW'(m_snap[pins.rd_row][pins.rd_chan]);
        end
        err_e = ERRCHK ? m_err : 2'b00;
        exp_q.push_back({m_tick, err_e, rd_e});
        #1;
        e = exp_q.pop_front();
        check_val("rd_data", 32'(pins.rd_data), 32'(e[CW-1:0]));
        check_val("frame_tick", 32'(pins.frame_tick), 32'(e[EW-1]));
        check_val("err", 32'(pins.err), 32'(e[CW+1:CW]));
    end

    // ---------------- readout select driver ----------------
    bit           hold_rd = 1'b0;
    logic [AW-1:0] rd_row_sel = '0;
    logic [1:0]    rd_chan_sel = '0;

    always @(negedge clk) begin
        if (hold_rd) begin
            pins.rd_row  = rd_row_sel;
            pins.rd_chan = rd_chan_sel;
        end else begin
            pins.rd_row  = AW'($urandom_range(0, ROWS - 1));
            pins.rd_chan = 2'($urandom_range(0, 3));
        end
    end

    // ---------------- driver tasks ----------------
    logic [2:0] row_buf [COLS];
    time        lat_time;

    task automatic fill_row(input int mode);
        for (int i = 0; i < COLS; i++)
            row_buf[i] = (mode == 0) ? 3'b000 : (mode == 1) ? 3'b111 : 3'($urandom);
    endtask

    task automatic shift_row(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pins.oclk = 1'b0;
            pins.rgb  = row_buf[i];
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            @(negedge clk);
            pins.oclk = 1'b1;
        end
    endtask

    task automatic do_lat(input int a);
        @(negedge clk);
        pins.oclk = 1'b0;
        pins.oe   = 1'b0;
        pins.lat  = 1'b1;
        pins.addr = AW'(a);
        lat_time  = $time;
        @(negedge clk);
        pins.lat  = 1'b0;
    endtask

    task automatic light(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pins.oe = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(negedge clk);
        pins.oe = 1'b0;
    endtask

    task automatic close_frame();
        fill_row(0);
        shift_row(COLS);
        do_lat(0);
    endtask

    task automatic read_check(input string tag, input int row, input int ch, input longint exp);
        rd_row_sel  = AW'(row);
        rd_chan_sel = 2'(ch);
        hold_rd     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val(tag, 32'(pins.rd_data), 32'(exp));
        hold_rd = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    time t_rel, t_a, t_b;

    initial begin
        pins.rgb = '0; pins.oclk = 1'b0; pins.lat = 1'b0; pins.oe = 1'b0; pins.addr = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pins.rgb  = 3'($urandom);
            pins.oclk = 1'($urandom);
            pins.lat  = 1'($urandom);
            pins.oe   = 1'($urandom);
            pins.addr = AW'($urandom);
        end
        check_val("reset_rd_data", 32'(pins.rd_data), 32'd0);
        check_val("reset_tick", 32'(pins.frame_tick), 32'd0);
        check_val("reset_err", 32'(pins.err), 32'd0);
        @(negedge clk);
        pins.rgb = '0; pins.oclk = 1'b0; pins.lat = 1'b0; pins.oe = 1'b0; pins.addr = '0;
        rst = 1'b1;
        t_rel = $time;

        // All-ones frame, 100 lit cycles per row.
        for (int r = 0; r < ROWS; r++) begin
            fill_row(1); shift_row(COLS); do_lat(r); light(100, 1'b0);
        end
        close_frame();
        t_a = lat_time;
        check_val("ones_tick", 32'(pins.frame_tick), 32'd1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 3; c++)
                read_check($sformatf("ones_r%0d_c%0d", r, c), r, c, 100);
        read_check("ones_frame", 0, 3, longint'((t_a - t_rel) / 10));

        // Probe column 3'b010 on row 3 only.
        for (int r = 0; r < ROWS; r++) begin
            fill_row(2);
            row_buf[PROBE] = (r == 3) ? 3'b010 : 3'b000;
            shift_row(COLS); do_lat(r); light(100, 1'b0);
        end
        close_frame();
        t_b = lat_time;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 3; c++)
                read_check($sformatf("g3_r%0d_c%0d", r, c), r, c,
                           (r == 3 && c == 1) ? 100 : 0);
        read_check("g3_frame", 5, 3, longint'((t_b - t_a) / 10));

        // Random frames, random lit patterns, occasional skipped rows.
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 4) == 0) continue;
                fill_row(2); shift_row(COLS); do_lat(r);
                light($urandom_range(5, 40), 1'b1);
            end
            close_frame();
        end

        // oclk rise coincident with lat rise.
        fill_row(2);
        row_buf[PROBE] = 3'b111;
        row_buf[PROBE + 1] = 3'b000;
        shift_row(COLS);
        @(negedge clk);
        pins.oclk = 1'b0; pins.rgb = 3'b000;
        @(negedge clk);
        pins.oclk = 1'b1; pins.lat = 1'b1; pins.addr = AW'(2);
        @(negedge clk);
        pins.lat = 1'b0;
        light(20, 1'b0);
        fill_row(2); shift_row(COLS - 1); do_lat(3);
        close_frame();
        for (int c = 0; c < 3; c++)
            read_check($sformatf("coinc_c%0d", c), 2, c, 20);
        check_val("coinc_err", 32'(pins.err), 32'd0);

        // Short row: 31 shifts before lat.
        fill_row(2); shift_row(COLS - 1); do_lat(1);
        @(negedge clk);
        check_val("short_err0", 32'(pins.err[0]), 32'(ERRCHK));
        fill_row(2); shift_row(COLS); do_lat(2); light(10, 1'b0);
        check_val("short_err0_held", 32'(pins.err[0]), 32'(ERRCHK));
        check_val("short_err1_clear", 32'(pins.err[1]), 32'd0);

        // lat and oe high together.
        fill_row(2); shift_row(COLS);
        @(negedge clk);
        pins.oclk = 1'b0; pins.oe = 1'b1; pins.lat = 1'b1; pins.addr = AW'(3);
        @(negedge clk);
        pins.lat = 1'b0; pins.oe = 1'b0;
        @(negedge clk);
        check_val("latoe_err1", 32'(pins.err[1]), 32'(ERRCHK));
        close_frame();

        // Reset mid-row discards partial state.
        fill_row(2); shift_row(10);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_rd_data", 32'(pins.rd_data), 32'd0);
        check_val("midrst_tick", 32'(pins.frame_tick), 32'd0);
        check_val("midrst_err", 32'(pins.err), 32'd0);
        pins.oclk = 1'b0; pins.lat = 1'b0; pins.oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 2; r < 5; r++) begin
            fill_row(2); shift_row(COLS); do_lat(r); light($urandom_range(5, 30), 1'b1);
        end
        close_frame();
        for (int c = 0; c < 3; c++)
            read_check($sformatf("post_rst_r0_c%0d", c), 0, c, 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_panel_receiver.md
Name: display_panel_receiver

Overview:
- Synthesizable HUB75-style panel model: the sink end of the pulse-width display driver's serial interface (rgb/oclk/lat/oe plus row address).
- Shifts in column data, latches rows, and measures per-row, per-channel on-time for one probe column.
- Publishes per-frame timing statistics through a small readout port.
- Used in self-checking benches and the on-chip loopback test build; runs on the driver's clock.

Parameters:
- rows, 8, panel rows per segment (power of two, >=2).
- columns, 32, pixels shifted per row (>=2).
- cntwidth, 24, width of all cycle counters.
- probe_column, 0, column index whose latched bits gate the on-time accumulators.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst  in  1  asynchronous, active-low reset.
- rgb  in  3  serial pixel bits {b,g,r}; bit0=r.
- oclk  in  1  shift clock; a rising edge is detected in the clk domain.
- lat  in  1  latch strobe; a rising edge is detected in the clk domain.
- oe  in  1  output enable; 1 = latched row lit.
- addr  in  $clog2(rows)  row address, sampled on lat rise.
- rd_row  in  $clog2(rows)  readout row select.
- rd_chan  in  2  readout select: 0=r, 1=g, 2=b, 3=frame cycle count (rd_row ignored).
- rd_data  out  cntwidth  registered snapshot value.
- frame_tick  out  1  one-cycle pulse; a new snapshot is valid.
- err  out  2  sticky protocol errors: [0]=shift count, [1]=lat while oe.

Behaviour:
- Reset (rst=0, async): edge registers, shift register, latch, latched_row, shift_cnt, accumulators, snapshot, frame counter, rd_data, frame_tick and err all clear to 0.
- Edge detect: oclk_rise = oclk & !oclk_q; lat_rise = lat & !lat_q. Both are combinational from registered history, so an edge is acted on in the cycle the input first reads high.
- oclk_rise: each channel's shift register shifts left and rgb enters bit0.
  - After columns shifts, column c sits at index columns-1-c (first bit shifted = column 0).
  - shift_cnt increments, saturating at columns+1.
- lat_rise: latch <= shift register (pre-shift value if oclk_rise coincides); latched_row <= addr; shift_cnt <= 0, or 1 if oclk_rise coincides.
- Accumulate, every cycle with oe=1: acc[latched_row][ch] += latch[ch][columns-1-probe_column], saturating at all-ones.
- frame_cycles increments every cycle, saturating.
- Frame boundary: lat_rise with addr < latched_row (wrap). In that cycle:
  - snapshot <= current accumulators and frame_cycles (values before this cycle's increment);
  - accumulators and frame_cycles restart, counting this cycle as the first of the new frame;
  - frame_tick is high the following cycle, for exactly one cycle.
- Startup: the first lat after reset with addr=0 is not a boundary; a boundary only occurs on a wrap.
- Readout: rd_data <= snapshot[rd_row][rd_chan] (or frame count when rd_chan=3), one-cycle latency, updated every cycle. Reading during frame_tick returns the new snapshot.
- Reset mid-row discards all partial state; no snapshot is produced.

Optional Feature:
- PANEL_RX_ERRCHK_EN defined:
  - err[0] sets on lat_rise when shift_cnt != columns.
  - err[1] sets on any cycle with lat=1 and oe=1.
  - Both bits are sticky until reset.
- Not defined: err is tied to 0 and no checking logic is generated.

Decomposition:
- Package display_pkg: channel index constants (CH_R, CH_G, CH_B, CH_FRAME) and the rd_chan encoding.
- One sub-module, display_edge_detect (registered rising-edge detector, async active-low reset), instantiated for oclk and lat.

Test Plan:
- Reset held, random inputs -> rd_data=0, frame_tick=0, err=0.
- rows=8, columns=32, probe 0: shift 32 ones per row, latch rows 0..7, oe high 100 cycles per row, then lat with addr=0 -> one frame_tick; r/g/b = 100 for every row; frame count equals the cycles between wraps.
- Probe column data 3'b010 on row 3 only -> rd_row=3: g=oe cycles, r=b=0; other rows all 0.
- Only 31 oclk edges before lat, with PANEL_RX_ERRCHK_EN -> err[0]=1, held through later good rows; without the macro -> err=0.
- lat and oe high in the same cycle -> err[1]=1 (macro on).
- oclk rise coincident with lat rise -> latch excludes the new bit; that row ends with shift_cnt=columns and no err[0].
